// File: rtl/pow5_arb_pkg.sv
// Shared types and helpers for the pow5 round-robin arbiter slice.
package pow5_arb_pkg;

  localparam int POW_STAGES = 5;
  localparam int MAX_REQ    = 8;
  localparam int TAG_IDW    = 3;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic               found;
    logic [TAG_IDW-1:0] idx;
  } pick_t;

  // Scans downward so the candidate closest to ptr is the last one written and wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [TAG_IDW-1:0] ptr,
                                    input int                 n);
    pick_t              r;
    logic [TAG_IDW:0]   sum;
    logic [TAG_IDW-1:0] sel;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        sum = {1'b0, ptr} + (TAG_IDW+1)'(k);
        if (sum >= (TAG_IDW+1)'(n)) begin
          sum = sum - (TAG_IDW+1)'(n);
        end
        sel = sum[TAG_IDW-1:0];
        if (req[sel]) begin
          r.found = 1'b1;
          r.idx   = sel;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pow5_tag_pipe.sv
// Requester-ID shift register running in lockstep with the x^5 engine,
// plus a count of the operations currently inside the engine.
module pow5_tag_pipe
  import pow5_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  issue,
  input  logic [TAG_IDW-1:0]    issue_id,
  input  logic                  pop,
  output logic [POW_STAGES-1:0] tag_vld,
  output tag_t                  last,
  output logic [2:0]            inflight
);

  tag_t stage [POW_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < POW_STAGES; k++) begin
        stage[k] <= '0;
      end
    end else if (en) begin
      stage[0] <= '{vld: issue, id: issue_id};
      for (int k = 1; k < POW_STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  // A simultaneous issue and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (en) begin
      if (issue && !pop) begin
        inflight <= inflight + 3'd1;
      end else if (pop && !issue) begin
        inflight <= inflight - 3'd1;
      end
    end
  end

  always_comb begin
    tag_vld = '0;
    for (int k = 0; k < POW_STAGES; k++) begin
      tag_vld[k] = stage[k].vld;
    end
  end

  assign last = stage[POW_STAGES-1];

endmodule

// File: rtl/pow_5_rr_arbiter.sv
// Round-robin arbiter sharing one 5-stage x^5 engine among N requesters;
// results return on one backpressured channel tagged with the requester ID.
module pow_5_rr_arbiter
  import pow5_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain,
  input  logic [N-1:0]          req_vld,
  input  logic [N*W-1:0]        req_arg,
  output logic [N-1:0]          req_rdy,
  output logic                  eng_clk_en,
  output logic                  eng_arg_vld,
  output logic [W-1:0]          eng_arg,
  input  logic [POW_STAGES-1:0] eng_res_vld,
  input  logic [POW_STAGES*W-1:0] eng_res,
  output logic                  out_vld,
  output logic [IDW-1:0]        out_id,
  output logic [W-1:0]          out_res,
  input  logic                  out_rdy,
  output logic [2:0]            inflight
);

  logic [TAG_IDW-1:0]    ptr;
  logic [MAX_REQ-1:0]    req_ext;
  pick_t                 pick;
  logic                  grant_ok;
  logic [POW_STAGES-1:0] tag_vld;
  logic [POW_STAGES-1:0] tag_vld_rev;
  tag_t                  last;
  logic                  unused_res;

  // Backpressure is realised purely by freezing the engine and the tag pipe together.
  assign eng_clk_en = !(out_vld && !out_rdy);

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req_vld;
    pick             = rr_pick(req_ext, ptr, N);
    grant_ok         = pick.found && eng_clk_en && !drain && !rst;
  end

  always_comb begin
    req_rdy = '0;
    eng_arg = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_ok && (pick.idx == TAG_IDW'(i))) begin
        req_rdy[i] = 1'b1;
        eng_arg    = req_arg[i*W +: W];
      end
    end
  end

  assign eng_arg_vld = |(req_vld & req_rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (eng_arg_vld) begin
      ptr <= (pick.idx == TAG_IDW'(N - 1)) ? '0 : pick.idx + TAG_IDW'(1);
    end
  end

  pow5_tag_pipe u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (eng_clk_en),
    .issue    (eng_arg_vld),
    .issue_id (pick.idx),
    .pop      (out_vld && out_rdy),
    .tag_vld  (tag_vld),
    .last     (last),
    .inflight (inflight)
  );

  assign out_vld    = last.vld;
  assign out_id     = IDW'(last.id);
  assign out_res    = eng_res[W-1:0];
  assign unused_res = ^eng_res[POW_STAGES*W-1:W];

  // Engine res_vld is numbered from the output end, the tag pipe from the input end.
  always_comb begin
    tag_vld_rev = '0;
    for (int k = 0; k < POW_STAGES; k++) begin
      tag_vld_rev[POW_STAGES-1-k] = tag_vld[k];
    end
  end

  assert property (@(posedge clk) disable iff (rst) tag_vld_rev == eng_res_vld)
    else $fatal(1, "tag pipe out of lockstep with engine");

endmodule

// File: tb/tb_pow_5_rr_arbiter.sv
// Self-checking bench for pow_5_rr_arbiter with a behavioural x^5 engine attached.
module tb_pow_5_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             drain;
  logic [N-1:0]     req_vld;
  logic [N*W-1:0]   req_arg;
  logic [N-1:0]     req_rdy;
  logic             eng_clk_en;
  logic             eng_arg_vld;
  logic [W-1:0]     eng_arg;
  logic [4:0]       eng_res_vld;
  logic [5*W-1:0]   eng_res;
  logic             out_vld;
  logic [IDW-1:0]   out_id;
  logic [W-1:0]     out_res;
  logic             out_rdy;
  logic [2:0]       inflight;

  always #5 clk = ~clk;

  pow_5_rr_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .drain       (drain),
    .req_vld     (req_vld),
    .req_arg     (req_arg),
    .req_rdy     (req_rdy),
    .eng_clk_en  (eng_clk_en),
    .eng_arg_vld (eng_arg_vld),
    .eng_arg     (eng_arg),
    .eng_res_vld (eng_res_vld),
    .eng_res     (eng_res),
    .out_vld     (out_vld),
    .out_id      (out_id),
    .out_res     (out_res),
    .out_rdy     (out_rdy),
    .inflight    (inflight)
  );

  // Behavioural stand-in for the pow_5_en_pipe_always engine.
  logic [4:0]   e_vld;
  logic [W-1:0] e_x [5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_vld <= '0;
    else if (eng_clk_en) e_vld <= {eng_arg_vld, e_vld[4:1]};
  end

  always_ff @(posedge clk) begin
    if (eng_clk_en) begin
      e_x[0] <= eng_arg;
      for (int k = 1; k < 5; k++) e_x[k] <= e_x[k-1];
    end
  end

  function automatic logic [W-1:0] eng_pow(input logic [W-1:0] x, input int e);
    logic [W-1:0] r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * x;
    return r;
  endfunction

  always_comb begin
    eng_res_vld = e_vld;
    eng_res     = '0;
    for (int b = 0; b < 5; b++) eng_res[b*W +: W] = eng_pow(e_x[4-b], 5 - b);
  end

  // Reference model: ordered list of in-flight ops with their age in enabled cycles.
  typedef struct { int id; int res; int age; } op_t;
  typedef struct { logic [N-1:0] vld; logic drn; logic [N-1:0] exp_rdy; } vec_t;

  op_t q[$];
  int  ptr_m;
  int  arg_m [N];
  int  grants[$];
  int  dlv_id[$];
  int  dlv_res[$];
  int  tests = 0;
  int  fails = 0;

  function automatic int refPow5(input int x);
    longint p;
    p = longint'(x);
    return int'((p * p * p * p * p) % 256);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelCycle();
    bit  exp_ov;
    bit  exp_en;
    int  win;
    int  idx;
    op_t op;
    exp_ov = (q.size() > 0) && (q[0].age >= 5);
    exp_en = !(exp_ov && !out_rdy);
    win = -1;
    if (exp_en && !drain) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (req_vld[idx]) begin
          win = idx;
          break;
        end
      end
    end
    checkOutput("out_vld", out_vld, exp_ov);
    if (exp_ov) begin
      checkOutput("out_id", out_id, q[0].id);
      checkOutput("out_res", out_res, q[0].res);
    end
    checkOutput("eng_clk_en", eng_clk_en, exp_en);
    checkOutput("req_rdy", req_rdy, (win >= 0) ? (1 << win) : 0);
    checkOutput("eng_arg_vld", eng_arg_vld, win >= 0);
    if (win >= 0) checkOutput("eng_arg", eng_arg, arg_m[win]);
    checkOutput("inflight", inflight, q.size());
    if (out_vld && out_rdy) begin
      dlv_id.push_back(int'(out_id));
      dlv_res.push_back(int'(out_res));
    end
    for (int i = 0; i < N; i++) if (req_rdy[i]) grants.push_back(i);
    if (exp_en) begin
      if (exp_ov) void'(q.pop_front());
      for (int j = 0; j < q.size(); j++) q[j].age = q[j].age + 1;
      if (win >= 0) begin
        op.id  = win;
        op.res = refPow5(arg_m[win]);
        op.age = 1;
        q.push_back(op);
        ptr_m = (win + 1) % N;
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] vld, input logic drn, input logic ordy);
    @(posedge clk);
    #1;
    req_vld = vld;
    drain   = drn;
    out_rdy = ordy;
    for (int i = 0; i < N; i++) req_arg[i*W +: W] = W'(arg_m[i]);
    @(negedge clk);
    modelCycle();
  endtask

  task automatic doReset(input logic [N-1:0] vld_during);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    req_vld = vld_during;
    drain   = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    checkOutput("rst out_vld", out_vld, 0);
    checkOutput("rst inflight", inflight, 0);
    checkOutput("rst req_rdy", req_rdy, 0);
    checkOutput("rst eng_arg_vld", eng_arg_vld, 0);
    checkOutput("rst eng_clk_en", eng_clk_en, 1);
    q.delete();
    ptr_m = 0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    req_vld = '0;
  endtask

  task automatic flush();
    for (int c = 0; c < 40 && (inflight != 0 || q.size() != 0); c++) applyStimulus('0, 1'b0, 1'b1);
    checkOutput("flush empty", inflight, 0);
  endtask

  vec_t tv [11];
  int   exp_fair [4];

  initial begin
    int  lat;
    int  issued;
    int  held_id;
    int  held_res;
    bit  found;

    rst = 1'b0; drain = 1'b0; req_vld = '0; req_arg = '0; out_rdy = 1'b1;
    for (int i = 0; i < N; i++) arg_m[i] = i + 2;
    #2 rst = 1'b1;
    #20 rst = 1'b0;

    // Arbitration table from a clean reset, pointer evolving row to row.
    tv[0]  = '{4'b0000, 1'b0, 4'b0000};
    tv[1]  = '{4'b0100, 1'b0, 4'b0100};
    tv[2]  = '{4'b0110, 1'b0, 4'b0010};
    tv[3]  = '{4'b1111, 1'b1, 4'b0000};
    tv[4]  = '{4'b1111, 1'b0, 4'b0100};
    tv[5]  = '{4'b1001, 1'b0, 4'b1000};
    tv[6]  = '{4'b1001, 1'b0, 4'b0001};
    tv[7]  = '{4'b0001, 1'b0, 4'b0001};
    tv[8]  = '{4'b0001, 1'b0, 4'b0001};
    tv[9]  = '{4'b1010, 1'b0, 4'b0010};
    tv[10] = '{4'b1111, 1'b0, 4'b0100};
    doReset('0);
    for (int v = 0; v < 11; v++) begin
      applyStimulus(tv[v].vld, tv[v].drn, 1'b1);
      checkOutput("table req_rdy", req_rdy, tv[v].exp_rdy);
    end
    flush();

    // Single op latency.
    doReset('0);
    arg_m[2] = 3;
    applyStimulus(4'b0100, 1'b0, 1'b1);
    found = 0;
    lat = -1;
    for (int c = 1; c <= 20 && !found; c++) begin
      applyStimulus('0, 1'b0, 1'b1);
      if (out_vld) begin
        found = 1;
        lat = c;
        checkOutput("single id", out_id, 2);
        checkOutput("single res", out_res, 243);
      end
    end
    checkOutput("single latency", lat, 5);
    flush();

    // Fairness with all requesters held.
    doReset('0);
    for (int i = 0; i < N; i++) arg_m[i] = i + 2;
    exp_fair = '{32, 243, 0, 53};
    grants.delete(); dlv_id.delete(); dlv_res.delete();
    repeat (12) applyStimulus(4'b1111, 1'b0, 1'b1);
    flush();
    for (int i = 0; i < 8; i++)
      checkOutput("fair grant", (grants.size() > i) ? grants[i] : -1, i % 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fair out id", (dlv_id.size() > i) ? dlv_id[i] : -1, i);
      checkOutput("fair out res", (dlv_res.size() > i) ? dlv_res[i] : -1, exp_fair[i]);
    end

    // Backpressure mid-stream.
    doReset('0);
    dlv_id.delete(); dlv_res.delete();
    issued = 0; held_id = 0; held_res = 0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) arg_m[i] = int'($urandom_range(0, 255));
      applyStimulus((issued < 8) ? 4'b0011 : 4'b0000, 1'b0, !(c >= 6 && c <= 8));
      if (|req_rdy) issued++;
      if (c == 6) begin
        checkOutput("bp stall out_vld", out_vld, 1);
        held_id = int'(out_id);
        held_res = int'(out_res);
      end
      if (c >= 6 && c <= 8) begin
        checkOutput("bp stall clk_en", eng_clk_en, 0);
        checkOutput("bp stall req_rdy", req_rdy, 0);
        checkOutput("bp held id", out_id, held_id);
        checkOutput("bp held res", out_res, held_res);
      end
      checkOutput("bp inflight bound", inflight <= 5, 1);
    end
    flush();
    checkOutput("bp delivered", dlv_id.size(), 8);

    // Drain with three ops in flight.
    doReset('0);
    repeat (3) applyStimulus(4'b0001, 1'b0, 1'b1);
    grants.delete(); dlv_id.delete(); dlv_res.delete();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(4'b1111, 1'b1, 1'b1);
      if (c == 0) checkOutput("drain inflight start", inflight, 3);
    end
    checkOutput("drain grants", grants.size(), 0);
    checkOutput("drain delivered", dlv_id.size(), 3);
    checkOutput("drain idle inflight", inflight, 0);

    // Reset with four ops in flight, pointer left at 3.
    doReset('0);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    applyStimulus(4'b0100, 1'b0, 1'b1);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    applyStimulus(4'b0100, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("pre-reset inflight", inflight, 4);
    doReset(4'b1111);
    dlv_id.delete(); dlv_res.delete();
    arg_m[1] = 2;
    arg_m[3] = 7;
    applyStimulus(4'b1010, 1'b0, 1'b1);
    checkOutput("post-reset grant", req_rdy, 4'b0010);
    flush();
    checkOutput("post-reset count", dlv_id.size(), 1);
    checkOutput("post-reset id", (dlv_id.size() > 0) ? dlv_id[0] : -1, 1);
    checkOutput("post-reset res", (dlv_res.size() > 0) ? dlv_res[0] : -1, 32);

    // Constrained-random traffic against the model.
    doReset('0);
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) arg_m[i] = int'($urandom_range(0, 255));
      applyStimulus(N'($urandom_range(0, 15)), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
